// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive datapath.
// - wls encodings and the data-bit count they select
// - frame sizing constants
// - the packed status word carried alongside each received character
package uart_pkg;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Longest frame: 8 data + parity + stop.
    localparam int FRAME_MAX   = 10;
    localparam int FRAME_CNT_W = 4;

    typedef struct packed {
        logic pe;
        logic fe;
        logic bi;
        logic ne;
    } rx_status_t;

    function automatic logic [FRAME_CNT_W-1:0] data_bits_f(input logic [1:0] wls);
        logic [FRAME_CNT_W-1:0] n;
        case (wls)
            WLS_5:   n = FRAME_CNT_W'(5);
            WLS_6:   n = FRAME_CNT_W'(6);
            WLS_7:   n = FRAME_CNT_W'(7);
            WLS_8:   n = FRAME_CNT_W'(8);
            default: n = FRAME_CNT_W'(5);
        endcase
        return n;
    endfunction

    // Captured samples per frame: data bits, optional parity, one stop bit.
    function automatic logic [FRAME_CNT_W-1:0] frame_len_f(input logic [1:0] wls,
                                                           input logic       pen);
        return data_bits_f(wls) + FRAME_CNT_W'(pen) + FRAME_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_receive_datapath_if.sv
// Strobe/feedback bundle between the UART receive FSM and its datapath.
// master : the FSM (drives strobes, reads line/frame status)
// slave  : the datapath (reads strobes, drives line/frame status)
// The strobes are single-cycle enables sampled on pclk; there is no
// back-pressure, the datapath acts on every cycle a strobe is high.
interface uart_receive_datapath_if;
    logic voting_shift_en;
    logic receive_shift_en;
    logic receive_frame_counter_en;
    logic receive_frame_counter_clear;
    logic error_check;
    logic uart_break;
    logic receive_load_en;

    logic uart_rxd_sync;
    logic rx_data;
    logic all_zero;
    logic receive_done;

    modport master (
        output voting_shift_en, receive_shift_en, receive_frame_counter_en,
               receive_frame_counter_clear, error_check, uart_break, receive_load_en,
        input  uart_rxd_sync, rx_data, all_zero, receive_done
    );

    modport slave (
        input  voting_shift_en, receive_shift_en, receive_frame_counter_en,
               receive_frame_counter_clear, error_check, uart_break, receive_load_en,
        output uart_rxd_sync, rx_data, all_zero, receive_done
    );
endinterface

// File: rtl/uart_rx_majority_vote.sv
// Line front end: SYNC_STAGES-flop synchroniser, 3-sample vote register and
// majority decision.
// Ports: clk, rst (sync, active high), line (raw rxd), shift_en (take a
// sample), unanimous (only with UART_RX_NOISE_DETECT_EN), line_sync, vote.
module uart_rx_majority_vote #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    input  logic shift_en,
`ifdef UART_RX_NOISE_DETECT_EN
    output logic unanimous,
`endif
    output logic line_sync,
    output logic vote
);

    // Idle line is high, so everything resets to ones to avoid a false start.
    logic [SYNC_STAGES-1:0] sync_ff;
    logic [2:0]             vote_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '1;
            vote_sr <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], line};
            if (shift_en) begin
                vote_sr <= {vote_sr[1:0], sync_ff[SYNC_STAGES-1]};
            end
        end
    end

    assign line_sync = sync_ff[SYNC_STAGES-1];
    assign vote      = (vote_sr[0] & vote_sr[1]) | (vote_sr[0] & vote_sr[2]) |
                       (vote_sr[1] & vote_sr[2]);

`ifdef UART_RX_NOISE_DETECT_EN
    assign unanimous = (&vote_sr) | (~|vote_sr);
`endif

endmodule

// File: rtl/uart_receive_datapath.sv
// UART receive datapath: line sampling, frame assembly, parity/framing/break
// checks and the character commit to the downstream receive buffer.
// Ports: pclk, preset (sync, active high), uart_rxd (async line),
//   wls/pen/eps/sp (line config, latched while the counter is cleared),
//   fsm (strobes in / line+frame status out),
//   rx_char, rx_pe, rx_fe, rx_bi, rx_ne, rx_load (committed character).
// rx_load is a one-cycle valid with no ready: the buffer must take rx_char
// and the flags in that cycle; they then hold until the next load.
// Optional: define UART_RX_NOISE_DETECT_EN to build the noise flag (rx_ne);
// otherwise rx_ne is constant 0.
module uart_receive_datapath
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_MAX    = 8
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    uart_rxd,
    input  logic [1:0]              wls,
    input  logic                    pen,
    input  logic                    eps,
    input  logic                    sp,
    uart_receive_datapath_if.slave  fsm,
    output logic [DATA_MAX-1:0]     rx_char,
    output logic                    rx_pe,
    output logic                    rx_fe,
    output logic                    rx_bi,
    output logic                    rx_ne,
    output logic                    rx_load
);

    logic [1:0]             cfg_wls;
    logic                   cfg_pen, cfg_eps, cfg_sp;
    logic [FRAME_CNT_W-1:0] frame_cnt, data_bits, frame_len;
    logic [FRAME_MAX-1:0]   frame_sr, sr_next, len_mask, data_mask, data_v;
    logic                   frame_fresh;
    logic                   line_sync, vote_bit, noise_now;
    logic                   pbit, pe_now, fe_now, pe_q, fe_q, pe_use, fe_use;
    logic                   brk_seen, brk_now;
    rx_status_t             status_q;

`ifdef UART_RX_NOISE_DETECT_EN
    logic vote_unanimous;
`endif

    uart_rx_majority_vote #(.SYNC_STAGES(SYNC_STAGES)) u_vote (
        .clk       (pclk),
        .rst       (preset),
        .line      (uart_rxd),
        .shift_en  (fsm.voting_shift_en),
`ifdef UART_RX_NOISE_DETECT_EN
        .unanimous (vote_unanimous),
`endif
        .line_sync (line_sync),
        .vote      (vote_bit)
    );

    assign fsm.uart_rxd_sync = line_sync;
    assign fsm.rx_data       = vote_bit;

    // Config is only sampled while the counter is held clear, so a frame in
    // flight always sees the settings it started with.
    always_ff @(posedge pclk) begin
        if (preset) begin
            cfg_wls <= WLS_5;
            cfg_pen <= 1'b0;
            cfg_eps <= 1'b0;
            cfg_sp  <= 1'b0;
        end else if (fsm.receive_frame_counter_clear) begin
            cfg_wls <= wls;
            cfg_pen <= pen;
            cfg_eps <= eps;
            cfg_sp  <= sp;
        end
    end

    assign data_bits = data_bits_f(cfg_wls);
    assign frame_len = frame_len_f(cfg_wls, cfg_pen);
    assign len_mask  = ~({FRAME_MAX{1'b1}} << frame_len);
    assign data_mask = ~({FRAME_MAX{1'b1}} << data_bits);
    assign data_v    = frame_sr & data_mask;

    always_ff @(posedge pclk) begin
        if (preset) begin
            frame_cnt <= '0;
        end else if (fsm.receive_frame_counter_clear) begin
            frame_cnt <= '0;
        end else if (fsm.receive_frame_counter_en && (frame_cnt != frame_len)) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

    // Bits left over from an aborted frame are discarded on the first
    // capture of the next frame rather than at clear time.
    always_comb begin
        sr_next = frame_fresh ? '0 : frame_sr;
        if (frame_cnt < FRAME_CNT_W'(FRAME_MAX)) begin
            sr_next[frame_cnt] = vote_bit;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            frame_sr    <= '0;
            frame_fresh <= 1'b1;
        end else begin
            if (fsm.receive_shift_en) begin
                frame_sr <= sr_next;
            end
            if (fsm.receive_frame_counter_clear) begin
                frame_fresh <= 1'b1;
            end else if (fsm.receive_shift_en) begin
                frame_fresh <= 1'b0;
            end
        end
    end

    assign fsm.receive_done = (frame_cnt == frame_len);
    assign fsm.all_zero     = ~|(frame_sr & len_mask);

    assign pbit   = frame_sr[data_bits];
    assign pe_now = cfg_sp ? (cfg_pen & (pbit != ~cfg_eps))
                           : (cfg_pen & ((^data_v) ^ pbit ^ ~cfg_eps));
    assign fe_now = ~frame_sr[frame_len - FRAME_CNT_W'(1)];

    // Same-cycle check and load must see this cycle's result, not the register.
    assign pe_use  = fsm.error_check ? pe_now : pe_q;
    assign fe_use  = fsm.error_check ? fe_now : fe_q;
    assign brk_now = brk_seen | fsm.uart_break;

    always_ff @(posedge pclk) begin
        if (preset) begin
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            brk_seen <= 1'b0;
        end else begin
            if (fsm.error_check) begin
                pe_q <= pe_now;
                fe_q <= fe_now;
            end
            if (rx_load) begin
                brk_seen <= 1'b0;
            end else if (fsm.uart_break) begin
                brk_seen <= 1'b1;
            end
        end
    end

`ifdef UART_RX_NOISE_DETECT_EN
    logic clr_q, noise_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            clr_q   <= 1'b0;
            noise_q <= 1'b0;
        end else begin
            clr_q <= fsm.receive_frame_counter_clear;
            if (fsm.receive_frame_counter_clear && !clr_q) begin
                noise_q <= 1'b0;
            end else if (fsm.receive_shift_en && !vote_unanimous) begin
                noise_q <= 1'b1;
            end
        end
    end

    assign noise_now = noise_q;
`else
    assign noise_now = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            rx_char  <= '0;
            status_q <= '0;
            rx_load  <= 1'b0;
        end else begin
            rx_load <= fsm.receive_load_en;
            if (fsm.receive_load_en) begin
                rx_char     <= brk_now ? '0 : DATA_MAX'(data_v[7:0]);
                status_q.pe <= pe_use & ~brk_now;
                status_q.fe <= fe_use | brk_now;
                status_q.bi <= brk_now;
                status_q.ne <= noise_now;
            end
        end
    end

    assign rx_pe = status_q.pe;
    assign rx_fe = status_q.fe;
    assign rx_bi = status_q.bi;
    assign rx_ne = status_q.ne;

endmodule

// File: tb/tb_uart_receive_datapath.sv
// Bench for uart_receive_datapath: directed frames from the test plan plus
// randomized frames, each scored against a character-level model of the
// UART rules held in an expected queue.
module tb_uart_receive_datapath;

    localparam int SYNC_STAGES = 2;
    localparam int DATA_MAX    = 8;
`ifdef UART_RX_NOISE_DETECT_EN
    localparam logic NOISE_EN = 1'b1;
`else
    localparam logic NOISE_EN = 1'b0;
`endif

    logic                pclk = 1'b0;
    logic                preset = 1'b1;
    logic                uart_rxd = 1'b1;
    logic [1:0]          wls = 2'b00;
    logic                pen = 1'b0, eps = 1'b0, sp = 1'b0;
    logic [DATA_MAX-1:0] rx_char;
    logic                rx_pe, rx_fe, rx_bi, rx_ne, rx_load;

    uart_receive_datapath_if bus ();

    uart_receive_datapath #(.SYNC_STAGES(SYNC_STAGES), .DATA_MAX(DATA_MAX)) dut (
        .pclk     (pclk),
        .preset   (preset),
        .uart_rxd (uart_rxd),
        .wls      (wls),
        .pen      (pen),
        .eps      (eps),
        .sp       (sp),
        .fsm      (bus),
        .rx_char  (rx_char),
        .rx_pe    (rx_pe),
        .rx_fe    (rx_fe),
        .rx_bi    (rx_bi),
        .rx_ne    (rx_ne),
        .rx_load  (rx_load)
    );

    // ---------------- clock ----------------
    always #5 pclk = ~pclk;

    // ---------------- scoreboard ----------------
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [11:0] exp_q[$];      // {ne, bi, fe, pe, char}
    logic [11:0] cmp_e;
    bit          started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge pclk) begin
        if (started && !preset && rx_load) begin
            if (exp_q.size() == 0) begin
                check("unexpected_load", 1, 0);
            end else begin
                cmp_e = exp_q.pop_front();
                check("load_word", {rx_ne, rx_bi, rx_fe, rx_pe, rx_char}, cmp_e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic vote_sample(input logic v);
        uart_rxd = v;
        repeat (SYNC_STAGES) tick();
        bus.voting_shift_en = 1'b1;
        tick();
        bus.voting_shift_en = 1'b0;
    endtask

    task automatic shift_bit(input logic [2:0] smp);
        vote_sample(smp[0]);
        vote_sample(smp[1]);
        vote_sample(smp[2]);
        bus.receive_shift_en         = 1'b1;
        bus.receive_frame_counter_en = 1'b1;
        tick();
        bus.receive_shift_en         = 1'b0;
        bus.receive_frame_counter_en = 1'b0;
    endtask

    // One frame as the FSM would run it. bits[i] is the i-th sampled line
    // bit (LSB-first data, then parity, then stop). glitch[i] makes the
    // three votes for that bit disagree while keeping the same majority.
    task automatic run_frame(input logic [1:0] w, input logic p, input logic e,
                             input logic s, input logic [9:0] bits,
                             input logic [9:0] glitch, input bit brk,
                             input bit merge_ec, input bit abort,
                             input logic [1:0] w_mid);
        int          db, fl, mask_so_far;
        logic        noise, par, exp_pbit, exp_pe, exp_fe;
        logic [7:0]  exp_ch;
        logic [9:0]  data;
        db = 5 + int'(w);
        fl = db + int'(p) + 1;
        wls = w; pen = p; eps = e; sp = s;
        bus.receive_frame_counter_clear = 1'b1;
        tick();
        bus.receive_frame_counter_clear = 1'b0;
        wls = w_mid;
        noise = 1'b0;
        for (int k = 0; k < fl; k++) begin
            if (glitch[k]) begin
                noise = 1'b1;
                shift_bit(bits[k] ? 3'b101 : 3'b010);
            end else begin
                shift_bit({3{bits[k]}});
            end
            mask_so_far = (1 << (k + 1)) - 1;
            check("all_zero", bus.all_zero, (int'(bits) & mask_so_far) == 0);
            check("receive_done", bus.receive_done, (k + 1) == fl);
            if (abort && k == fl / 2) return;
        end
        if (brk) begin
            bus.uart_break = 1'b1;
            tick();
            bus.uart_break = 1'b0;
        end
        data     = bits & 10'((1 << db) - 1);
        par      = ($countones(data) % 2) == 1;
        exp_pbit = s ? !e : (e ? par : !par);
        exp_pe   = p && (bits[db] != exp_pbit) && !brk;
        exp_fe   = !bits[fl-1] || brk;
        exp_ch   = brk ? 8'h00 : data[7:0];
        exp_q.push_back({NOISE_EN & noise, logic'(brk), exp_fe, exp_pe, exp_ch});
        if (!merge_ec) begin
            bus.error_check = 1'b1;
            tick();
            bus.error_check = 1'b0;
        end
        bus.error_check     = merge_ec;
        bus.receive_load_en = 1'b1;
        tick();
        bus.receive_load_en = 1'b0;
        bus.error_check     = 1'b0;
        check("load_pulse", rx_load, 1);
        tick();
        check("load_drop", rx_load, 0);
        check("char_hold", rx_char, exp_ch);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.voting_shift_en             = 1'b0;
        bus.receive_shift_en            = 1'b0;
        bus.receive_frame_counter_en    = 1'b0;
        bus.receive_frame_counter_clear = 1'b0;
        bus.error_check                 = 1'b0;
        bus.uart_break                  = 1'b0;
        bus.receive_load_en             = 1'b0;
        preset = 1'b1;
        repeat (3) tick();
        check("rst_rx_data", bus.rx_data, 1);
        check("rst_sync", bus.uart_rxd_sync, 1);
        check("rst_all_zero", bus.all_zero, 1);
        check("rst_done", bus.receive_done, 0);
        check("rst_char", rx_char, 0);
        check("rst_flags", {rx_ne, rx_bi, rx_fe, rx_pe, rx_load}, 0);
        preset  = 1'b0;
        started = 1;
        tick();

        // 8N1 0xA5
        run_frame(2'b11, 0, 0, 0, 10'h1A5, 10'h000, 0, 0, 0, 2'b11);
        check("a5_char", rx_char, 8'hA5);
        check("a5_flags", {rx_bi, rx_fe, rx_pe}, 3'b000);

        // 7E1 0x41 with wrong parity bit 1
        run_frame(2'b10, 1, 1, 0, 10'h1C1, 10'h000, 0, 0, 0, 2'b10);
        check("7e1_char", rx_char, 8'h41);
        check("7e1_pe", rx_pe, 1);

        // stick parity, eps=0, parity bit 1 is correct
        run_frame(2'b10, 1, 0, 1, 10'h1C1, 10'h000, 0, 1, 0, 2'b10);
        check("stick_pe", rx_pe, 0);

        // 5N1 all-ones data, stop sampled 0
        run_frame(2'b00, 0, 0, 0, 10'h01F, 10'h000, 0, 0, 0, 2'b00);
        check("5n1_fe", rx_fe, 1);
        check("5n1_char", rx_char, 8'h1F);

        // break: line low for the whole 8N1 frame
        run_frame(2'b11, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 2'b11);
        check("brk_flags", {rx_bi, rx_fe, rx_pe}, 3'b110);
        check("brk_char", rx_char, 8'h00);

        // vote glitch handling
        vote_sample(1'b1); vote_sample(1'b0); vote_sample(1'b1);
        check("vote_101", bus.rx_data, 1);
        vote_sample(1'b0); vote_sample(1'b1); vote_sample(1'b0);
        check("vote_010", bus.rx_data, 0);
        run_frame(2'b11, 0, 0, 0, 10'h1FF, 10'h001, 0, 0, 0, 2'b11);
        check("glitch_ne", rx_ne, NOISE_EN);
        check("glitch_char", rx_char, 8'hFF);

        // wls changed mid-frame, then the new length applies
        run_frame(2'b11, 0, 0, 0, 10'h13C, 10'h000, 0, 0, 0, 2'b00);
        check("midcfg_char", rx_char, 8'h3C);
        run_frame(2'b00, 0, 0, 0, 10'h035, 10'h000, 0, 1, 0, 2'b00);
        check("len6_char", rx_char, 8'h15);

        // aborted frame full of ones, then a clean frame
        run_frame(2'b11, 0, 0, 0, 10'h3FF, 10'h000, 0, 0, 1, 2'b11);
        run_frame(2'b11, 0, 0, 0, 10'h100, 10'h000, 0, 0, 0, 2'b11);
        check("post_abort_char", rx_char, 8'h00);

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            run_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      10'($urandom_range(0, 1023)),
                      ($urandom_range(0, 3) == 0) ? 10'(1 << $urandom_range(0, 9)) : 10'h000,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)));
        end

        // preset in the middle of a frame
        wls = 2'b11;
        bus.receive_frame_counter_clear = 1'b1;
        tick();
        bus.receive_frame_counter_clear = 1'b0;
        shift_bit(3'b000); shift_bit(3'b000); shift_bit(3'b000);
        check("pre_rst_rx_data", bus.rx_data, 0);
        preset = 1'b1;
        tick();
        check("midrst_rx_data", bus.rx_data, 1);
        check("midrst_sync", bus.uart_rxd_sync, 1);
        check("midrst_done", bus.receive_done, 0);
        check("midrst_all_zero", bus.all_zero, 1);
        check("midrst_char", rx_char, 0);
        check("midrst_load", rx_load, 0);
        preset   = 1'b0;
        uart_rxd = 1'b1;
        repeat (4) tick();

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_receive_datapath.md
Name: uart_receive_datapath

Overview:
- Datapath companion of the UART receive state machine. Synchronises and majority-votes the serial line, and returns rx_data, all_zero and receive_done to the FSM.
- Consumes the FSM strobes: shift, count, clear, error_check, break, load.
- Assembles the frame, checks parity and framing, and presents one received character plus status flags to the receive buffer/FIFO downstream.

Parameters:
- SYNC_STAGES, 2, number of flops in the uart_rxd input synchroniser (min 2).
- DATA_MAX, 8, maximum data bits per character.

Ports:
- pclk  input  1  system clock.
- preset  input  1  synchronous, active-high reset.
- uart_rxd  input  1  raw serial line, asynchronous to pclk.
- wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits.
- pen  input  1  parity enable.
- eps  input  1  even parity select (1=even).
- sp  input  1  stick parity.
- voting_shift_en  input  1  FSM strobe: shift the synchronised line into the vote register.
- receive_shift_en  input  1  FSM strobe: store rx_data at the frame_cnt index.
- receive_frame_counter_en  input  1  increment frame_cnt.
- receive_frame_counter_clear  input  1  clear frame_cnt; also latches config.
- error_check  input  1  evaluate parity/framing this cycle.
- uart_break  input  1  FSM break indication (level).
- receive_load_en  input  1  commit character to outputs.
- uart_rxd_sync  output  1  synchronised line, used by the FSM for start detection.
- rx_data  output  1  majority vote of the last 3 line samples.
- all_zero  output  1  all captured frame bits are 0.
- receive_done  output  1  frame_cnt == frame_len.
- rx_char  output  DATA_MAX  received character, zero-extended.
- rx_pe  output  1  parity error.
- rx_fe  output  1  framing error.
- rx_bi  output  1  break interrupt.
- rx_ne  output  1  noise error (see Optional Feature).
- rx_load  output  1  one-cycle pulse: rx_char and the flags are valid.

Behaviour:
- Reset:
  - Synchroniser and vote register reset to all-ones, so uart_rxd_sync=1 and rx_data=1.
  - frame_cnt=0 and frame_sr=0.
  - rx_char=0; rx_pe, rx_fe, rx_bi, rx_ne, rx_load = 0.
  - Latched config resets to wls=00, pen=0.
- Synchroniser: uart_rxd passes through SYNC_STAGES flops; the output is uart_rxd_sync.
- Vote register:
  - vote_sr[2:0] shifts in uart_rxd_sync on voting_shift_en.
  - rx_data = majority(vote_sr), combinational from the register.
- Config latch:
  - wls/pen/eps/sp are registered every cycle while receive_frame_counter_clear=1.
  - They are held while it is 0, so mid-frame config changes are ignored until the next frame.
- Frame length: data_bits = 5 + wls; frame_len = data_bits + pen + 1. Range 6..10, so frame_cnt is 4 bits.
- Frame counter:
  - Clear has priority over enable.
  - On enable, frame_cnt increments, saturating at frame_len.
- Capture: on receive_shift_en, frame_sr[frame_cnt] <= rx_data, using the pre-increment value. The frame is LSB-first, so frame_sr[0] = d0.
- receive_done: combinational frame_cnt == frame_len. It is high in the cycle after the last sample.
- all_zero: combinational; high when frame_sr[frame_len-1:0] == 0.
- Parity check, done when error_check=1:
  - pbit = frame_sr[data_bits]; x = XOR of the data bits.
  - sp=0: pe_n = pen & (x ^ pbit ^ ~eps).
  - sp=1: pe_n = pen & (pbit != ~eps).
- Framing check, done when error_check=1: fe_n = (frame_sr[frame_len-1] == 0).
- Break:
  - brk_seen is a sticky register, set while uart_break=1.
  - It is cleared on the cycle after rx_load.
- Load: on receive_load_en, in the next cycle:
  - rx_load=1.
  - rx_char = data bits, zero-extended.
  - rx_pe = pe_n; rx_fe = fe_n | brk_seen; rx_bi = brk_seen.
  - On a break load, rx_char=0 and rx_pe=0.
  - Flags hold until the next load. rx_load is low otherwise.
- Latency: receive_load_en to rx_load is 1 cycle.
- Abort: if the FSM aborts (clear reasserts without a load), frame_sr is kept but never committed. It is zeroed on the next clear-to-count transition (first shift of the next frame).
- Simultaneous error_check and receive_load_en: the load uses the pe_n/fe_n computed in that same cycle (bypass), not stale values.
- preset mid-frame returns everything to reset values in the next cycle.

Optional Feature:
- Macro: UART_RX_NOISE_DETECT_EN.
- When defined:
  - On each receive_shift_en, a noise register is set if the vote_sr bits are not unanimous.
  - The register clears on receive_frame_counter_clear rising.
  - On load, rx_ne = the noise register.
- When undefined: rx_ne is tied to 0, and no extra flops are built.

Decomposition:
- Package uart_pkg holds:
  - wls encoding constants (WLS_5..WLS_8).
  - FRAME_MAX=10 and FRAME_CNT_W=4.
  - A packed struct rx_status_t {pe, fe, bi, ne}.
- One sub-module, uart_rx_majority_vote, containing the synchroniser, vote_sr, the rx_data majority, and the unanimity signal.

Test Plan:
- 8N1, char 0xA5, stop=1, with strobes driven as the FSM does:
  - rx_load pulses 1 cycle after load_en.
  - rx_char=0xA5; pe=fe=bi=0.
  - receive_done rises after 9 shifts.
- 7E1, data 0x41, parity bit 1 (wrong; correct is 0) → rx_char=0x41, rx_pe=1. Same with sp=1, eps=0 and pbit=1 → rx_pe=0.
- 5N1, stop bit sampled 0 → rx_fe=1, rx_char masked to 5 bits (0x1F for all-ones data).
- Line held low for 10 samples at 8N1:
  - all_zero=1; uart_break asserted, then load.
  - rx_bi=1, rx_fe=1, rx_char=0x00.
- Vote glitch: samples 1,0,1 → rx_data=1. With UART_RX_NOISE_DETECT_EN, the following load has rx_ne=1; without the macro, rx_ne=0.
- wls changed from 11 to 00 mid-frame → frame_len stays 9 (8N1) for the current frame; the next frame uses frame_len 6. preset mid-frame → rx_data=1 and frame_cnt=0 next cycle.
